sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver for the MCU peripheral fabric; the fan-out counterpart to the multi-input reduction gates.
- Assembles NrOfBits serial samples, qualified by a strobe, into one parallel word.
- Presents the word on a valid/ready output handshake with double buffering and a sticky overrun flag.
- Applies a per-bit output inversion mask, analogous to the gate bubble masks.

---
 rtl/sipo_deserializer.sv | 163 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out receiver.
// Collects NrOfBits strobed serial samples into one word, presents it on a
// double-buffered valid/ready output with a sticky overrun flag, and applies
// a per-bit inversion mask at the output register.
// Optional feature macro: DESER_PARITY_EN (even-parity bit after each word,
// reported on Parity_Error). Without it Parity_Error is tied to 0.
module sipo_deserializer #(
    parameter int                  NrOfBits   = 8,
    parameter logic [NrOfBits-1:0] InvertMask = '0,
    parameter bit                  MsbFirst   = 1'b0
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Serial_In,
    input  logic                Bit_Valid,
    input  logic                Frame_Start,
    input  logic                Word_Ready,
    input  logic                Overrun_Clr,
    output logic [NrOfBits-1:0] Word_Out,
    output logic                Word_Valid,
    output logic                Overrun,
    output logic [5:0]          Bit_Count,
    output logic                Parity_Error
);

`ifdef DESER_PARITY_EN
    localparam int TotalBits = NrOfBits + 1;
`else
    localparam int TotalBits = NrOfBits;
`endif
    localparam logic [5:0] LastCnt = 6'(TotalBits);
    localparam logic [5:0] DataCnt = 6'(NrOfBits);

    typedef enum logic [1:0] {IDLE, SHIFT, COMPLETE} state_t;

    state_t              state, state_nx;
    logic [5:0]          cnt_nx;
    logic                take_bit;
    logic                first_bit;
    logic                data_bit;
    logic                complete;
    logic                word_load;
    logic                overrun_set;
    logic [NrOfBits-1:0] sreg;

    // State register and bit counter
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Bit_Count <= '0;
        end else begin
            state     <= state_nx;
            Bit_Count <= cnt_nx;
        end
    end

    // Next-state logic: Frame_Start overrides the sequence and may carry bit 0
    always_comb begin
        state_nx  = state;
        cnt_nx    = Bit_Count;
        take_bit  = 1'b0;
        first_bit = 1'b0;
        if (Frame_Start) begin
            take_bit  = Bit_Valid;
            first_bit = Bit_Valid;
            cnt_nx    = Bit_Valid ? 6'd1 : 6'd0;
            state_nx  = Bit_Valid ? SHIFT : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (Bit_Valid) begin
                        take_bit  = 1'b1;
                        first_bit = 1'b1;
                        cnt_nx    = 6'd1;
                        state_nx  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (Bit_Valid) begin
                        take_bit = 1'b1;
                        cnt_nx   = Bit_Count + 6'd1;
                        if (cnt_nx == LastCnt)
                            state_nx = COMPLETE;
                    end
                end
                COMPLETE: begin
                    // strobes here are ignored; the word moves to the output
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
                default: begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Completion and handshake qualifiers
    always_comb begin
        complete    = (state == COMPLETE);
        data_bit    = first_bit || (Bit_Count < DataCnt);
        overrun_set = complete && Word_Valid && !Word_Ready;
        word_load   = complete && !overrun_set;
    end

    // Shift register; a trailing parity bit is not shifted into the word
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sreg <= '0;
        end else if (take_bit && data_bit) begin
            if (MsbFirst)
                sreg <= {sreg[NrOfBits-2:0], Serial_In};
            else
                sreg <= {Serial_In, sreg[NrOfBits-1:1]};
        end
    end

    // Output buffer: load on completion unless the old word is still unaccepted
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Word_Out   <= '0;
            Word_Valid <= 1'b0;
        end else if (word_load) begin
            Word_Out   <= sreg ^ InvertMask;
            Word_Valid <= 1'b1;
        end else if (Word_Valid && Word_Ready) begin
            Word_Valid <= 1'b0;
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            Overrun <= 1'b0;
        else
            Overrun <= overrun_set | (Overrun & ~Overrun_Clr);
    end

`ifdef DESER_PARITY_EN
    logic par_acc;

    // Running XOR over data and parity bits of the current word
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            par_acc <= 1'b0;
        else if (take_bit)
            par_acc <= first_bit ? Serial_In : (par_acc ^ Serial_In);
    end

    // Parity result travels with the word it belongs to
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            Parity_Error <= 1'b0;
        else if (word_load)
            Parity_Error <= par_acc;
    end
`else
    assign Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench for sipo_deserializer.
// Two instances share one stimulus stream: u0 with defaults, u1 with
// InvertMask=0x0F and MsbFirst=1. A bit-queue reference model builds the
// expected words; a negedge monitor pops and compares on every handshake.
module tb_sipo_deserializer;
    localparam int NB = 8;
`ifdef DESER_PARITY_EN
    localparam int TOT = NB + 1;
`else
    localparam int TOT = NB;
`endif

    typedef struct packed {
        logic [7:0] w;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, sd, bv, fs, rdy, oclr;
    logic [7:0] wo0, wo1;
    logic       wv0, wv1, ov0, ov1, pe0, pe1;
    logic [5:0] bc0, bc1;

    exp_t q0[$];
    exp_t q1[$];
    bit   mbits[$];
    int   exp_cnt = 0;
    bit   gap = 0;
    bit   sb_push = 1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.NrOfBits(NB)) u0 (
        .Clock(clk), .Reset_n(rst_n), .Serial_In(sd), .Bit_Valid(bv),
        .Frame_Start(fs), .Word_Ready(rdy), .Overrun_Clr(oclr),
        .Word_Out(wo0), .Word_Valid(wv0), .Overrun(ov0), .Bit_Count(bc0),
        .Parity_Error(pe0));

    sipo_deserializer #(.NrOfBits(NB), .InvertMask(8'h0F), .MsbFirst(1'b1)) u1 (
        .Clock(clk), .Reset_n(rst_n), .Serial_In(sd), .Bit_Valid(bv),
        .Frame_Start(fs), .Word_Ready(rdy), .Overrun_Clr(oclr),
        .Word_Out(wo1), .Word_Valid(wv1), .Overrun(ov1), .Bit_Count(bc1),
        .Parity_Error(pe1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word from the first NB received bits, placed by bit order, then masked
    function automatic logic [7:0] mk_word(input bit msb, input logic [7:0] mask);
        logic [7:0] w = '0;
        for (int i = 0; i < NB; i++) begin
            if (msb) w[NB-1-i] = mbits[i];
            else     w[i]      = mbits[i];
        end
        return w ^ mask;
    endfunction

    // Drive one cycle, advance the model on the edge, check Bit_Count after it
    task automatic step(input bit v, input bit d, input bit f);
        logic p;
        bv = v; sd = d; fs = f;
        gap = 0;
        @(posedge clk);
        if (!rst_n) begin
            mbits.delete();
            exp_cnt = 0;
        end else begin
            if (f) mbits.delete();
            if (v) mbits.push_back(d);
            if (mbits.size() == TOT) begin
                p = 1'b0;
`ifdef DESER_PARITY_EN
                foreach (mbits[i]) p ^= mbits[i];
`endif
                if (sb_push) begin
                    q0.push_back('{w: mk_word(1'b0, 8'h00), pe: p});
                    q1.push_back('{w: mk_word(1'b1, 8'h0F), pe: p});
                end
                exp_cnt = TOT;
                gap = 1;
                mbits.delete();
            end else begin
                exp_cnt = mbits.size();
            end
        end
        #1;
        chk("bit_count0", 32'(bc0), 32'(exp_cnt));
        chk("bit_count1", 32'(bc1), 32'(exp_cnt));
    endtask

    // Send a word (data bits, optional parity bit) followed by the gap cycle
    task automatic send_word(input logic [7:0] val, input bit msb_order, input bit bad_par);
        for (int i = 0; i < NB; i++)
            step(1'b1, val[msb_order ? NB-1-i : i], 1'b0);
`ifdef DESER_PARITY_EN
        step(1'b1, (^val) ^ bad_par, 1'b0);
`else
        if (bad_par) begin end
`endif
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compare on every accepted word
    always @(negedge clk) begin : mon
        exp_t e0, e1;
        if (rst_n && rdy) begin
            if (wv0) begin
                if (q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb0_unexpected: got word %0h with no expected entry", wo0);
                end else begin
                    e0 = q0.pop_front();
                    chk("sb0_word", 32'(wo0), 32'(e0.w));
                    chk("sb0_perr", 32'(pe0), 32'(e0.pe));
                end
            end
            if (wv1) begin
                if (q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb1_unexpected: got word %0h with no expected entry", wo1);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_word", 32'(wo1), 32'(e1.w));
                    chk("sb1_perr", 32'(pe1), 32'(e1.pe));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; sd = 0; bv = 0; fs = 0; rdy = 1'b1; oclr = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_word0", 32'(wo0), 32'h0);
        chk("rst_word1", 32'(wo1), 32'h0);
        chk("rst_valid", 32'(wv0), 32'h0);
        chk("rst_ovr",   32'(ov0), 32'h0);
        chk("rst_perr",  32'(pe0), 32'h0);
        rst_n = 1'b1;
        step(0, 0, 0);

        // 0xA5 LSB first == 0xA5 MSB first (bit pattern 1,0,1,0,0,1,0,1)
        for (int i = 0; i < NB; i++) step(1'b1, 1'((8'hA5 >> i) & 1), 1'b0);
`ifdef DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b0);
`endif
        chk("lat_not_yet", 32'(wv0), 32'h0);
        step(0, 0, 0);
        chk("lat_valid0", 32'(wv0), 32'h1);
        chk("lat_valid1", 32'(wv1), 32'h1);
        chk("a5_word0", 32'(wo0), 32'hA5);
        chk("a5_word1", 32'(wo1), 32'hAA);
        chk("a5_perr",  32'(pe0), 32'h0);
        step(0, 0, 0);
        chk("lat_one_cycle", 32'(wv0), 32'h0);

`ifdef DESER_PARITY_EN
        send_word(8'hA5, 1'b0, 1'b1);
        chk("bad_par_perr0", 32'(pe0), 32'h1);
        chk("bad_par_perr1", 32'(pe1), 32'h1);
        step(0, 0, 0);
`endif

        // Overrun: second word dropped, old word held
        rdy = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0);
        sb_push = 0;
        send_word(8'h3C, 1'b0, 1'b1);
        sb_push = 1;
        step(0, 0, 0);
        chk("ovr_word0", 32'(wo0), 32'hA5);
        chk("ovr_word1", 32'(wo1), 32'hAA);
        chk("ovr_valid", 32'(wv0), 32'h1);
        chk("ovr_flag0", 32'(ov0), 32'h1);
        chk("ovr_flag1", 32'(ov1), 32'h1);
        chk("ovr_perr_held", 32'(pe0), 32'h0);
        oclr = 1'b1;
        step(0, 0, 0);
        oclr = 1'b0;
        chk("ovr_cleared", 32'(ov0), 32'h0);
        chk("ovr_still_valid", 32'(wv0), 32'h1);
        rdy = 1'b1;
        step(0, 0, 0);
        chk("ovr_drain", 32'(wv0), 32'h0);

        // Frame_Start resync with bit 0 of 0x3C in the same cycle
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(1'b1, 1'b0, 1'b1);
        chk("fs_count", 32'(bc0), 32'h1);
        for (int i = 1; i < NB; i++) step(1'b1, 1'((8'h3C >> i) & 1), 1'b0);
`ifdef DESER_PARITY_EN
        step(1'b1, ^(8'h3C), 1'b0);
`endif
        step(0, 0, 0);
        chk("fs_valid", 32'(wv0), 32'h1);
        chk("fs_word", 32'(wo0), 32'h3C);
        step(0, 0, 0);

        // Reset mid-word, then a clean word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(0, 0, 0);
        rst_n = 1'b1;
        chk("mrst_word0", 32'(wo0), 32'h0);
        chk("mrst_word1", 32'(wo1), 32'h0);
        chk("mrst_valid", 32'(wv0), 32'h0);
        chk("mrst_ovr",   32'(ov0), 32'h0);
        chk("mrst_cnt",   32'(bc0), 32'h0);
        send_word(8'h81, 1'b0, 1'b0);
        chk("post_rst_word", 32'(wo0), 32'h81);
        chk("post_rst_valid", 32'(wv0), 32'h1);
        step(0, 0, 0);

        // Randomized stream: strobe gaps, occasional resync, random data
        for (int c = 0; c < 600; c++) begin
            if (gap) step(0, 0, 0);
            else step($urandom_range(0, 9) < 7, 1'($urandom & 1), $urandom_range(0, 29) == 0);
        end
        for (int c = 0; c < 4; c++) step(0, 0, 0);
        chk("ovr_random", 32'(ov0), 32'h0);
        chk("sb0_drained", 32'(q0.size()), 32'h0);
        chk("sb1_drained", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
